// File: rtl/money_pkg.sv
// rtl/money_pkg.sv - shared key codes, entry states and money constants
package money_pkg;

    localparam int MONEY_W = 8;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_BKSP  = 4'd11;
    localparam logic [3:0] KEY_ENTER = 4'd12;

    localparam logic [MONEY_W-1:0] PRICE_5  = 8'd5;
    localparam logic [MONEY_W-1:0] PRICE_10 = 8'd10;
    localparam logic [MONEY_W-1:0] PRICE_20 = 8'd20;
    localparam logic [MONEY_W-1:0] PRICE_30 = 8'd30;

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_shift3.sv
// rtl/bcd_shift3.sv - three-digit BCD echo register: insert-left, shift-right, clear
module bcd_shift3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_shl,
    input  logic       i_shr,
    input  logic [3:0] i_digit,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            d2 <= 4'd0;
            d1 <= 4'd0;
            d0 <= 4'd0;
        end else if (i_clear) begin
            d2 <= 4'd0;
            d1 <= 4'd0;
            d0 <= 4'd0;
        end else if (i_shl) begin
            d2 <= d1;
            d1 <= d0;
            d0 <= i_digit;
        end else if (i_shr) begin
            d0 <= d1;
            d1 <= d2;
            d2 <= 4'd0;
        end
    end

endmodule

// File: rtl/money_entry.sv
// rtl/money_entry.sv - keypad digit accumulator committing an 8-bit amount on ENTER (option MONEY_ENTRY_DENOM_EN)
module money_entry
    import money_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int MAX_VALUE  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    input  logic               lock,
    output logic [MONEY_W-1:0] money,
    output logic               money_valid,
    output logic [3:0]         d2,
    output logic [3:0]         d1,
    output logic [3:0]         d0,
    output logic               entry_err,
    output logic               busy
);

    localparam logic [13:0] LP_MAX_VALUE  = 14'(MAX_VALUE);
    localparam logic [1:0]  LP_MAX_DIGITS = 2'(MAX_DIGITS);

    entry_state_t r_state;
    logic [9:0]   r_acc;
    logic [1:0]   r_ndig;

    logic        w_key;
    logic        w_digit;
    logic [13:0] w_new;
    logic        w_digit_ok;
    logic        w_enter_ok;
    logic        w_shl;
    logic        w_shr;
    logic        w_clear;

    assign w_key   = key_valid && !lock;
    assign w_digit = is_digit(key_code);
    assign w_new   = {4'd0, r_acc} * 14'd10 + {10'd0, key_code};

    // The 10-bit accumulator plus a 14-bit candidate lets overflow be caught before it is stored.
    assign w_digit_ok = (r_ndig != LP_MAX_DIGITS) && (w_new <= LP_MAX_VALUE);

`ifdef MONEY_ENTRY_DENOM_EN
    assign w_enter_ok = (r_acc % 10'd5) == 10'd0;
`else
    assign w_enter_ok = 1'b1;
`endif

    assign w_shl   = w_key && w_digit && (r_state == IDLE || w_digit_ok);
    assign w_shr   = w_key && (r_state == ENTRY) && (key_code == KEY_BKSP);
    assign w_clear = w_key && (r_state == ENTRY) &&
                     (key_code == KEY_CLEAR || (key_code == KEY_ENTER && w_enter_ok));

    assign busy = (r_state == ENTRY);

    bcd_shift3 u_digits (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_shl   (w_shl),
        .i_shr   (w_shr),
        .i_digit (key_code),
        .d2      (d2),
        .d1      (d1),
        .d0      (d0)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_acc       <= 10'd0;
            r_ndig      <= 2'd0;
            money       <= '0;
            money_valid <= 1'b0;
            entry_err   <= 1'b0;
        end else begin
            money_valid <= 1'b0;
            entry_err   <= 1'b0;
            if (w_key) begin
                case (r_state)
                    IDLE: begin
                        if (w_digit) begin
                            r_acc   <= {6'd0, key_code};
                            r_ndig  <= 2'd1;
                            r_state <= ENTRY;
                        end else if (key_code == KEY_ENTER || key_code == KEY_BKSP) begin
                            entry_err <= 1'b1;
                        end
                    end
                    ENTRY: begin
                        if (w_digit) begin
                            if (w_digit_ok) begin
                                r_acc  <= w_new[9:0];
                                r_ndig <= r_ndig + 2'd1;
                            end else begin
                                entry_err <= 1'b1;
                            end
                        end else if (key_code == KEY_BKSP) begin
                            r_acc  <= r_acc / 10'd10;
                            r_ndig <= r_ndig - 2'd1;
                            if (r_ndig == 2'd1)
                                r_state <= IDLE;
                        end else if (key_code == KEY_CLEAR) begin
                            r_acc   <= 10'd0;
                            r_ndig  <= 2'd0;
                            r_state <= IDLE;
                        end else if (key_code == KEY_ENTER) begin
                            if (w_enter_ok) begin
                                money       <= r_acc[MONEY_W-1:0];
                                money_valid <= 1'b1;
                                r_acc       <= 10'd0;
                                r_ndig      <= 2'd0;
                                r_state     <= IDLE;
                            end else begin
                                entry_err <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_money_entry.sv
// tb/tb_money_entry.sv - randomized and directed check of money_entry against a digit-list model
module tb_money_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       lock = 1'b0;
    logic [7:0] money;
    logic       money_valid;
    logic [3:0] d2, d1, d0;
    logic       entry_err;
    logic       busy;

    int checks = 0;
    int failures = 0;

    int q[$];
    int m_money = 0;
    bit m_mv = 0;
    bit m_err = 0;

    always #5 clk = ~clk;

    money_entry dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .lock        (lock),
        .money       (money),
        .money_valid (money_valid),
        .d2          (d2),
        .d1          (d1),
        .d0          (d0),
        .entry_err   (entry_err),
        .busy        (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int q_value();
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    function automatic int q_digit(input int pos);
        if (pos < q.size()) return q[q.size() - 1 - pos];
        return 0;
    endfunction

    task automatic model(input bit r, input bit kv, input bit lk, input int code);
        m_mv  = 0;
        m_err = 0;
        if (!r) begin
            q.delete();
            m_money = 0;
        end else if (kv && !lk) begin
            if (code <= 9) begin
                if (q.size() == 0) q.push_back(code);
                else if (q.size() == 3 || q_value() * 10 + code > 255) m_err = 1;
                else q.push_back(code);
            end else if (code == 10) begin
                q.delete();
            end else if (code == 11) begin
                if (q.size() == 0) m_err = 1;
                else void'(q.pop_back());
            end else if (code == 12) begin
                if (q.size() == 0) m_err = 1;
`ifdef MONEY_ENTRY_DENOM_EN
                else if (q_value() % 5 != 0) m_err = 1;
`endif
                else begin
                    m_money = q_value();
                    m_mv = 1;
                    q.delete();
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit kv, input bit lk, input int code);
        @(negedge clk);
        rst       = r;
        key_valid = kv;
        lock      = lk;
        key_code  = 4'(code);
        @(posedge clk);
        #1;
        model(r, kv, lk, code);
        check("money", money, m_money);
        check("money_valid", money_valid, m_mv);
        check("entry_err", entry_err, m_err);
        check("d2", d2, q_digit(2));
        check("d1", d1, q_digit(1));
        check("d0", d0, q_digit(0));
        check("busy", busy, q.size() != 0);
    endtask

    task automatic key(input int code);
        step(1, 1, 0, code);
        step(1, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);

        key(1); key(2); key(0);
        check("digits_120", {d2, d1, d0}, 12'h120);
        step(1, 1, 0, 12);
        check("money_120", money, 120);
        check("mv_120", money_valid, 1);
        step(1, 0, 0, 0);
        check("mv_drop", money_valid, 0);

        key(2); key(5); key(6); key(12);
        check("money_25", money, 25);

        key(1); key(0); key(0); key(7); key(12);
        check("money_100", money, 100);

        key(4); key(9); key(11); key(12);
        check("money_4", money, 4);
        key(11);
        check("money_hold_4", money, 4);

        key(5);
        step(0, 1, 0, 0);
        check("money_reset", money, 0);
        step(1, 1, 1, 7);
        check("lock_err", entry_err, 0);
        check("lock_busy", busy, 0);

        key(2); key(3); key(12); key(11); key(5); key(12);
`ifdef MONEY_ENTRY_DENOM_EN
        check("money_denom", money, 25);
`else
        check("money_denom", money, 5);
`endif

        key(13); key(14); key(15); key(10); key(0); key(5); key(12);
        check("money_lead0", money, 5);

        for (int i = 0; i < 3000; i++) begin
            int code;
            code = ($urandom % 3 == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            step(($urandom % 250) != 0, ($urandom % 4) != 0, ($urandom % 10) == 0, code);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/money_entry.md
Name: money_entry

Overview:
- Keypad-side counterpart of the money display path.
- Accepts decimal key presses one digit at a time and accumulates them into an 8-bit binary amount.
- Echoes the in-progress BCD digits for the display, and commits the amount to the ticket controller on ENTER.
- Sits between the keypad debouncer/encoder and the ticket-sale FSM. The committed money value feeds the change and display logic.

Parameters:
- MAX_DIGITS, 3, maximum decimal digits accepted per entry (1..3).
- MAX_VALUE, 255, largest committable amount; must fit in 8 bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low (rst==0 resets on the next clk edge)
- key_valid  input  1  one-cycle strobe; key_code is valid this cycle
- key_code  input  4  0-9 digit, 10 CLEAR, 11 BACKSPACE, 12 ENTER, 13-15 ignored
- lock  input  1  ticket FSM busy; while high, all keys are ignored
- money  output  8  committed binary amount, held until the next commit or reset
- money_valid  output  1  one-cycle pulse, the cycle after an accepted ENTER
- d2,d1,d0  output  4 each  in-progress BCD digits (d0 least significant), for display
- entry_err  output  1  one-cycle pulse on any rejected key
- busy  output  1  high while in state ENTRY

Behaviour:
- Interface (decided): one clock, clk. Reset rst is synchronous and active-low.
- Reset values: state IDLE, acc=0, ndig=0, money=0, money_valid=0, entry_err=0, d2=d1=d0=0, busy=0. Reset wins over a simultaneous key_valid. Reset mid-entry discards the partial value.
- Latency: a key sampled with key_valid=1 at edge N updates acc, digits and outputs at edge N. Pulses are high for exactly the cycle after edge N.
- Internal registers: acc (10 bits, to detect overflow), ndig (2 bits).
- States:
  - IDLE: no digits pending. A digit key stores acc=digit, ndig=1 and goes to ENTRY. ENTER or BACKSPACE raises entry_err and stays in IDLE. CLEAR is a no-op.
  - ENTRY, digit key: compute new=acc*10+digit.
    - If ndig==MAX_DIGITS or new>MAX_VALUE: entry_err, state unchanged.
    - Else acc=new, ndig+1, digits shift left (d2<=d1, d1<=d0, d0<=digit).
  - ENTRY, BACKSPACE: acc=acc/10, digits shift right with zero fill, ndig-1. If ndig reaches 0, go to IDLE.
  - ENTRY, CLEAR: acc=0, ndig=0, digits 0, go to IDLE.
  - ENTRY, ENTER: money<=acc[7:0], money_valid pulse, then acc, ndig and digits cleared, go to IDLE.
- Leading zero digit: accepted and counted in ndig (e.g. "0","5" gives acc=5 with ndig=2).
- Ignored keys: codes 13-15 do nothing and raise no error. Any key while lock=1 is ignored with no error, and the state is held.
- money is never modified except by an accepted ENTER or reset.

Optional Feature:
- Macro MONEY_ENTRY_DENOM_EN.
- Defined: ENTER is accepted only if acc%5==0. Otherwise entry_err pulses, no commit, and the state stays ENTRY with digits kept.
- Undefined: any acc from 0 to MAX_VALUE commits.

Decomposition:
- Shared package money_pkg holds:
  - key code constants KEY_CLEAR=10, KEY_BKSP=11, KEY_ENTER=12;
  - state enum IDLE/ENTRY;
  - MONEY_W=8 and the ticket price constants 5/10/20/30 used elsewhere.
- One natural sub-module: bcd_shift3, the 3-digit BCD shift register with shift-left-insert, shift-right, and clear.

Test Plan:
- Reset then keys 1,2,0,ENTER -> d2..d0 shows 1,2,0 after the third key; money=120 with a 1-cycle money_valid; digits then return to 0,0,0.
- Keys 2,5,6 -> the 6 is rejected with entry_err; acc stays 25; ENTER -> money=25.
- Keys 1,0,0,7 -> the 4th digit is rejected with entry_err (digit limit); ENTER -> money=100.
- Keys 4,9,BACKSPACE,ENTER -> money=4. Then BACKSPACE in IDLE -> entry_err, money still 4.
- Keys 5 then rst=0 for one cycle together with key_valid=1, key 0 -> all outputs 0 and money=0; lock=1 with key 7 -> no change, no error.
- With MONEY_ENTRY_DENOM_EN defined: keys 2,3,ENTER -> entry_err, no commit. Then BACKSPACE,5 (acc=25), ENTER -> money=25.
